// File: rtl/blctrl_pkg.sv
// Shared definitions for the BLCtrl ESC I2C responder.
// Provides the default target address, the I2C byte bit count and the
// responder state enumeration.
package blctrl_pkg;

  localparam logic [6:0] BLCTRL_BASE_ADDR = 7'h29;
  localparam logic [3:0] I2C_BITS         = 4'd8;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StRxData,
    StRxAck,
    StTxData,
    StTxAck,
    StWaitStop
  } resp_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one asynchronous I2C line: 2-flop synchronizer, stability filter
// and one-cycle edge strobes on the filtered level.
// Ports:
//   clk     system clock
//   rst_n   synchronous active-low reset (filtered level resets to 1, bus idle)
//   line_i  raw bus level
//   level_o filtered level; changes only after FILTER_LEN equal samples
//   rise_o  one-cycle strobe on a filtered 0->1 change (coincides with new level)
//   fall_o  one-cycle strobe on a filtered 1->0 change (coincides with new level)
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, rise_q, fall_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        // FILTER_LEN consecutive samples disagreed with the held level
        level_q <= sync2_q;
        rise_q  <= sync2_q;
        fall_q  <= ~sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/blctrl_i2c_responder.sv
// I2C target emulating one BLCtrl ESC. A write to ADDRESS latches the first
// data byte as the motor speed; a read returns the latched speed. A watchdog
// zeroes the speed when no speed write arrives for TIMEOUT_CYCLES clocks.
// Ports:
//   clk          system clock (16 MHz)
//   rst_n        synchronous active-low reset
//   scl_i/sda_i  bus levels
//   sda_o        SDA drive value (always 0)
//   sda_t        SDA tristate, 1 = released
//   speed_o      last accepted speed byte (0 after reset or failsafe)
//   speed_valid  one-cycle pulse when a write updates speed_o
//   addressed    high from address ACK until STOP, START or master NACK
//   timeout      high while the failsafe is active
module blctrl_i2c_responder
  import blctrl_pkg::*;
#(
  parameter logic [6:0]  ADDRESS        = BLCTRL_BASE_ADDR,
  parameter int unsigned FILTER_LEN     = 3,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1600000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  output logic [7:0] speed_o,
  output logic       speed_valid,
  output logic       addressed,
  output logic       timeout
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (scl_i),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (sda_i),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  resp_state_e state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        drive_q, drive_d;      // 1 = pull SDA low
  logic        rw_q, rw_d;
  logic        first_q, first_d;      // next received byte is the first of the transaction
  logic        addressed_q, addressed_d;
  logic [7:0]  speed_q, speed_d;
  logic        speed_valid_q, speed_valid_d;
  logic [31:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;
  logic        write_evt;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    drive_d       = drive_q;
    rw_d          = rw_q;
    first_d       = first_q;
    addressed_d   = addressed_q;
    write_evt     = 1'b0;

    if (start_det) begin
      state_d     = StAddr;
      bit_cnt_d   = '0;
      drive_d     = 1'b0;
      addressed_d = 1'b0;
      first_d     = 1'b1;
    end else if (stop_det) begin
      state_d     = StIdle;
      drive_d     = 1'b0;
      addressed_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise && bit_cnt_q != I2C_BITS) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
            // On the R/W bit, shift_q[6:0] already holds the full address
            if (bit_cnt_q == I2C_BITS - 4'd1 && shift_q[6:0] != ADDRESS) begin
              state_d = StWaitStop;
            end
          end else if (scl_fall && bit_cnt_q == I2C_BITS) begin
            drive_d     = 1'b1;
            rw_d        = shift_q[0];
            addressed_d = 1'b1;
            state_d     = StAddrAck;
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            if (rw_q) begin
              // Read: first data bit goes out on this same fall
              drive_d   = ~speed_q[7];
              shift_d   = {speed_q[6:0], 1'b0};
              bit_cnt_d = 4'd1;
              state_d   = StTxData;
            end else begin
              drive_d   = 1'b0;
              bit_cnt_d = '0;
              state_d   = StRxData;
            end
          end
        end
        StRxData: begin
          if (scl_rise && bit_cnt_q != I2C_BITS) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == I2C_BITS - 4'd1 && first_q) begin
              write_evt = 1'b1;
              first_d   = 1'b0;
            end
          end else if (scl_fall && bit_cnt_q == I2C_BITS) begin
            drive_d = 1'b1;
            state_d = StRxAck;
          end
        end
        StRxAck: begin
          if (scl_fall) begin
            drive_d   = 1'b0;
            bit_cnt_d = '0;
            state_d   = StRxData;
          end
        end
        StTxData: begin
          if (scl_fall) begin
            if (bit_cnt_q == I2C_BITS) begin
              drive_d = 1'b0;
              state_d = StTxAck;
            end else begin
              drive_d   = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        StTxAck: begin
          if (scl_rise) begin
            if (!sda_lvl) begin
              shift_d   = speed_q;
              bit_cnt_d = '0;
              state_d   = StTxData;
            end else begin
              addressed_d = 1'b0;
              state_d     = StWaitStop;
            end
          end
        end
        StWaitStop: drive_d = 1'b0;
        default: begin
          state_d = StIdle;
          drive_d = 1'b0;
        end
      endcase
    end
  end

  // Watchdog and speed register; a speed write beats a same-cycle timeout
  always_comb begin
    speed_d       = speed_q;
    speed_valid_d = 1'b0;
    wd_d          = wd_q;
    timeout_d     = timeout_q;
    if (write_evt) begin
      speed_d       = {shift_q[6:0], sda_lvl};
      speed_valid_d = 1'b1;
      wd_d          = '0;
      timeout_d     = 1'b0;
    end else if (wd_q < TIMEOUT_CYCLES) begin
      wd_d = wd_q + 32'd1;
      if (wd_q == TIMEOUT_CYCLES - 32'd1) begin
        speed_d   = '0;
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      drive_q       <= 1'b0;
      rw_q          <= 1'b0;
      first_q       <= 1'b0;
      addressed_q   <= 1'b0;
      speed_q       <= '0;
      speed_valid_q <= 1'b0;
      wd_q          <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      drive_q       <= drive_d;
      rw_q          <= rw_d;
      first_q       <= first_d;
      addressed_q   <= addressed_d;
      speed_q       <= speed_d;
      speed_valid_q <= speed_valid_d;
      wd_q          <= wd_d;
      timeout_q     <= timeout_d;
    end
  end

  assign sda_o       = 1'b0;
  assign sda_t       = ~drive_q;
  assign speed_o     = speed_q;
  assign speed_valid = speed_valid_q;
  assign addressed   = addressed_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_blctrl_i2c_responder.sv
// Bench for blctrl_i2c_responder: bit-banged I2C master on a wired-AND bus,
// transaction-level model of the expected speed/failsafe behaviour.
`timescale 1ns/1ps
module tb_blctrl_i2c_responder;

  localparam logic [6:0] ADDR = 7'h29;
  localparam int         T    = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_o, sda_t, speed_valid, addressed, timeout;
  logic [7:0] speed_o;

  assign sda_line = sda_m & (sda_t ? 1'b1 : sda_o);

  blctrl_i2c_responder #(
    .ADDRESS       (ADDR),
    .FILTER_LEN    (3),
    .TIMEOUT_CYCLES(32'd1000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_o      (sda_o),
    .sda_t      (sda_t),
    .speed_o    (speed_o),
    .speed_valid(speed_valid),
    .addressed  (addressed),
    .timeout    (timeout)
  );

  always #31.25 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         q = 8;                // quarter SCL period in clocks
  int         last_write_cyc = 0;   // cycle of last accepted speed write or reset
  int         sv_count = 0;
  logic [7:0] exp_speed = 8'h00;
  logic [7:0] pending = 8'h00;
  bit         quiet = 1'b0;         // bus idle and DUT settled
  logic       prev_sda_t = 1'b1;
  logic [7:0] wbuf [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int age();
    return cyc - last_write_cyc;
  endfunction

  // Per-cycle compare against the model
  initial begin : compare
    int a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n) begin
        chk("sda_o_zero", sda_o, 0);
        if (sda_t !== prev_sda_t) chk("sda_t_change_with_scl_low", scl_m, 0);
        if (speed_valid === 1'b1) begin
          sv_count++;
          chk("valid_speed_value", speed_o, pending);
        end
        if (quiet) begin
          a = age();
          chk("idle_addressed", addressed, 0);
          if (a < T - 20) begin
            chk("idle_speed", speed_o, exp_speed);
            chk("idle_timeout", timeout, 0);
          end else if (a > T + 20) begin
            chk("failsafe_speed", speed_o, 0);
            chk("failsafe_timeout", timeout, 1);
          end
        end
      end
      prev_sda_t = sda_t;
    end
  end

  initial begin : hard_stop
    repeat (120000) @(posedge clk);
    $display("FAIL global_time_limit: actual=expired required=finish");
    $fatal(1, "time limit");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_bit(input bit b, input bit glitch, output bit line);
    tick(q);
    sda_m = b;
    tick(q);
    scl_m = 1'b1;
    tick(q);
    line = sda_line;
    if (glitch) begin
      sda_m = ~b;
      tick(1);
      sda_m = b;
      tick(q - 1);
    end else begin
      tick(q);
    end
    scl_m = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d, input bit glitch, output bit ack);
    bit l;
    for (int i = 7; i >= 0; i--) wr_bit(d[i], glitch, l);
    wr_bit(1'b1, 1'b0, ack);
  endtask

  task automatic rd_byte(input bit nack, output logic [7:0] d);
    bit l;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wr_bit(1'b1, 1'b0, l);
      d = {d[6:0], l};
    end
    wr_bit(nack, 1'b0, l);
    chk("read_ack_bit_line", l, nack);
  endtask

  task automatic i2c_start();
    tick(q);
    sda_m = 1'b0;
    tick(2 * q);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(q);
    sda_m = 1'b0;
    tick(q);
    scl_m = 1'b1;
    tick(2 * q);
    sda_m = 1'b1;
    tick(2 * q);
  endtask

  function automatic int txn_len(input int nbytes);
    return nbytes * 36 * q + 8 * q;
  endfunction

  // Keep the failsafe from firing in the middle of a transaction
  task automatic guard(input int len);
    if (age() < T + 30 && age() + len + 30 > T) begin
      while (age() < T + 30) tick(1);
    end
  endtask

  task automatic do_write(input logic [6:0] a, input int n, input bit glitch);
    bit ack;
    bit match;
    int sv0;
    match = (a == ADDR);
    guard(txn_len(n + 1));
    quiet = 1'b0;
    if (match && n > 0) pending = wbuf[0];
    sv0 = sv_count;
    i2c_start();
    wr_byte({a, 1'b0}, glitch, ack);
    chk("addr_ack", ack, !match);
    chk("addressed_after_addr", addressed, match);
    for (int i = 0; i < n; i++) begin
      wr_byte(wbuf[i], 1'b0, ack);
      if (i == 0 && match) begin
        last_write_cyc = cyc - 6 * q;
        exp_speed = wbuf[0];
      end
      chk("data_ack", ack, !match);
      chk("addressed_in_data", addressed, match);
    end
    i2c_stop();
    tick(10);
    chk("valid_pulse_count", sv_count - sv0, (match && n > 0) ? 1 : 0);
    quiet = 1'b1;
  endtask

  task automatic do_read(input logic [6:0] a, input int n, output logic [7:0] d);
    bit         ack;
    bit         match;
    logic [7:0] exp;
    match = (a == ADDR);
    d = 8'h00;
    guard(txn_len(n + 1));
    quiet = 1'b0;
    exp = (age() > T + 20) ? 8'h00 : exp_speed;
    i2c_start();
    wr_byte({a, 1'b1}, 1'b0, ack);
    chk("rd_addr_ack", ack, !match);
    if (match) begin
      for (int i = 0; i < n; i++) begin
        rd_byte(i == n - 1, d);
        chk("read_byte", d, exp);
        chk("addressed_read", addressed, (i != n - 1));
      end
    end
    i2c_stop();
    tick(10);
    quiet = 1'b1;
  endtask

  initial begin : main
    logic [7:0] rd;
    logic [7:0] ab;
    logic [6:0] ra;
    bit         l;
    int         w;
    int         op;
    int         n;

    rst_n = 1'b0;
    tick(3);
    chk("rst_sda_t", sda_t, 1);
    chk("rst_sda_o", sda_o, 0);
    chk("rst_speed", speed_o, 8'h00);
    chk("rst_valid", speed_valid, 0);
    chk("rst_addressed", addressed, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    last_write_cyc = cyc;
    quiet = 1'b1;
    tick(5);

    // 200 kHz write of 0x80
    q = 20;
    wbuf[0] = 8'h80;
    do_write(ADDR, 1, 1'b0);
    chk("t1_speed_80", speed_o, 8'h80);
    q = 8;

    // Wrong address: no ACK, speed unchanged
    wbuf[0] = 8'h40;
    do_write(7'h2B, 1, 1'b0);
    chk("t2_speed_kept", speed_o, 8'h80);

    // Read back
    wbuf[0] = 8'h80;
    do_write(ADDR, 1, 1'b0);
    do_read(ADDR, 1, rd);
    chk("t3_read_80", rd, 8'h80);

    // Multi-byte write keeps only the first byte
    wbuf[0] = 8'h10;
    wbuf[1] = 8'h20;
    wbuf[2] = 8'h30;
    do_write(ADDR, 3, 1'b0);
    chk("t4_speed_10", speed_o, 8'h10);

    // Failsafe and recovery
    wbuf[0] = 8'h55;
    do_write(ADDR, 1, 1'b0);
    tick(T + 100);
    chk("t5_failsafe_speed", speed_o, 8'h00);
    chk("t5_failsafe_flag", timeout, 1);
    wbuf[0] = 8'h22;
    do_write(ADDR, 1, 1'b0);
    chk("t5_recover_speed", speed_o, 8'h22);
    chk("t5_recover_flag", timeout, 0);

    // Glitches: idle bus, then on every SCL-high phase of the address byte
    sda_m = 1'b0;
    tick(1);
    sda_m = 1'b1;
    tick(20);
    chk("t6_idle_glitch", addressed, 0);
    wbuf[0] = 8'h3C;
    do_write(ADDR, 1, 1'b1);
    chk("t6_glitch_write", speed_o, 8'h3C);

    // Reset while the address ACK is driven
    q = 20;
    guard(txn_len(2));
    quiet = 1'b0;
    ab = {ADDR, 1'b0};
    i2c_start();
    for (int i = 7; i >= 0; i--) wr_bit(ab[i], 1'b0, l);
    w = 0;
    while (sda_t !== 1'b0 && w < 4 * q) begin
      tick(1);
      w++;
    end
    chk("t7_ack_driven", sda_t, 0);
    rst_n = 1'b0;
    tick(1);
    chk("t7_rst_release", sda_t, 1);
    chk("t7_rst_addressed", addressed, 0);
    chk("t7_rst_speed", speed_o, 8'h00);
    rst_n = 1'b1;
    exp_speed = 8'h00;
    last_write_cyc = cyc;
    i2c_stop();
    tick(10);
    quiet = 1'b1;
    q = 8;
    wbuf[0] = 8'h5A;
    do_write(ADDR, 1, 1'b0);
    chk("t7_after_reset_write", speed_o, 8'h5A);

    // Randomized traffic
    for (int it = 0; it < 25; it++) begin
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) begin
        ra = 7'($urandom);
        if (ra == ADDR) ra = ra ^ 7'h01;
      end else begin
        ra = ADDR;
      end
      if (op < 6) begin
        n = $urandom_range(0, 2);
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        do_write(ra, n, 1'b0);
      end else begin
        n = $urandom_range(1, 2);
        do_read(ra, n, rd);
      end
      if ($urandom_range(0, 4) == 0) tick(T + $urandom_range(50, 300));
      else tick($urandom_range(5, 200));
    end

    quiet = 1'b0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
